// File: rtl/score_reporter.sv
// Captures one inference result and streams it to the UART as a framed,
// XOR-checksummed byte packet over a valid/ready byte interface.
module score_reporter #(
   parameter logic [7:0] HEADER_BYTE = 8'hAA,
   parameter bit         SEND_SCORES = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inference_done,
   input  logic [3:0]   predicted_digit,
   input  logic [319:0] class_scores,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         report_done,
   output logic         overrun
);

   localparam logic [5:0] LAST = SEND_SCORES ? 6'd42 : 6'd2;

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state;
   state_t         state_nx;
   logic [3:0]     snap_digit;
   logic [319:0]   snap_scores;
   logic [5:0]     idx;
   logic [7:0]     chk;
   logic [7:0]     score_bytes [64];
   logic           xfer;
   logic           is_last;
   logic [5:0]     idx_nx;
   logic [7:0]     chk_nx;
   logic [7:0]     byte_nx;

   assign xfer    = (state == SEND) && tx_ready;
   assign is_last = (idx == LAST);
   assign idx_nx  = idx + 6'd1;
   // the header (index 0) never enters the checksum
   assign chk_nx  = (idx == 6'd0) ? chk : (chk ^ tx_data);

   always_comb begin
      score_bytes = '{default: 8'h00};
      for (int c = 0; c < 10; c++) begin
         for (int b = 0; b < 4; b++) begin
            score_bytes[6'(4*c+b)] = snap_scores[32*c+24-8*b +: 8];
         end
      end
   end

   always_comb begin
      byte_nx = score_bytes[idx_nx - 6'd2];
      if (idx_nx == LAST) begin
         byte_nx = chk_nx;
      end else if (idx_nx == 6'd1) begin
         byte_nx = {4'h0, snap_digit};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (inference_done) state_nx = SEND;
         SEND: if (xfer && is_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == SEND);
      tx_valid = (state == SEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_digit  <= '0;
         snap_scores <= '0;
         idx         <= '0;
         chk         <= '0;
         tx_data     <= '0;
         report_done <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         report_done <= 1'b0;
         if (inference_done && (state == SEND)) begin
            overrun <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (inference_done) begin
                  snap_digit  <= predicted_digit;
                  snap_scores <= class_scores;
                  tx_data     <= HEADER_BYTE;
                  chk         <= '0;
                  idx         <= '0;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (is_last) begin
                     report_done <= 1'b1;
                  end else begin
                     chk     <= chk_nx;
                     idx     <= idx_nx;
                     tx_data <= byte_nx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_reporter.sv
// Directed checks of score_reporter: packet framing, checksum,
// backpressure, overrun, snapshot isolation and reset abort.
module tb_score_reporter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inference_done = 1'b0;
   logic         m_done = 1'b0;
   logic [3:0]   predicted_digit = '0;
   logic [319:0] class_scores = '0;
   logic         tx_ready = 1'b1;
   logic         m_ready = 1'b1;
   logic [7:0]   tx_data, m_tx_data;
   logic         tx_valid, m_tx_valid;
   logic         busy, m_busy;
   logic         report_done, m_report_done;
   logic         overrun, m_overrun;

   int checks = 0;
   int failures = 0;

   logic [7:0] got [64];
   logic [7:0] exp_b [64];

   typedef struct {
      logic [3:0]   digit;
      logic [319:0] scores;
      logic [7:0]   chk;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   score_reporter #(.HEADER_BYTE(8'hAA), .SEND_SCORES(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .inference_done(inference_done),
      .predicted_digit(predicted_digit), .class_scores(class_scores),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .report_done(report_done), .overrun(overrun)
   );

   score_reporter #(.HEADER_BYTE(8'hAA), .SEND_SCORES(1'b0)) mini (
      .clk(clk), .rst_n(rst_n), .inference_done(m_done),
      .predicted_digit(predicted_digit), .class_scores(class_scores),
      .tx_data(m_tx_data), .tx_valid(m_tx_valid), .tx_ready(m_ready),
      .busy(m_busy), .report_done(m_report_done), .overrun(m_overrun)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic build_exp(input logic [3:0] d, input logic [319:0] s);
      logic [7:0] x;
      exp_b[0] = 8'hAA;
      exp_b[1] = {4'h0, d};
      for (int c = 0; c < 10; c++)
         for (int b = 0; b < 4; b++)
            exp_b[2+4*c+b] = s[32*c+24-8*b +: 8];
      x = 8'h00;
      for (int i = 1; i <= 41; i++) x = x ^ exp_b[i];
      exp_b[42] = x;
   endtask

   // Drives one pulse, then accepts bytes until report_done.
   task automatic run_pkt(input logic [3:0] d, input logic [319:0] s,
                          input int stall_at, input int ovr_at,
                          output int nb, output int cyc);
      int stalls;
      bit inj;
      logic [7:0] held;
      @(negedge clk);
      predicted_digit = d;
      class_scores = s;
      inference_done = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      inference_done = 1'b0;
      predicted_digit = ~d;
      class_scores = ~s;
      nb = 0; cyc = 0; stalls = 0; inj = 0; held = '0;
      while (cyc < 200) begin
         cyc++;
         if (report_done) break;
         inference_done = 1'b0;
         if (nb == ovr_at && !inj) begin
            inference_done = 1'b1;
            predicted_digit = d + 4'd1;
            inj = 1;
         end
         tx_ready = 1'b1;
         if (nb == stall_at && stalls < 5) begin
            tx_ready = 1'b0;
            if (stalls == 0) held = tx_data;
            else begin
               check("stall_data", {24'h0, tx_data}, {24'h0, held});
               check("stall_valid", {31'h0, tx_valid}, 32'h1);
            end
            stalls++;
         end
         if (tx_valid && tx_ready && nb < 64) begin
            got[nb] = tx_data;
            nb++;
         end
         @(negedge clk);
      end
      inference_done = 1'b0;
      tx_ready = 1'b1;
      check("no_timeout", {31'h0, cyc < 200}, 32'h1);
   endtask

   task automatic check_pkt(input int vi, input int nb);
      build_exp(vecs[vi].digit, vecs[vi].scores);
      check("pkt_len", nb, 43);
      for (int i = 0; i < 43; i++)
         check($sformatf("byte%0d_v%0d", i, vi), {24'h0, got[i]},
               {24'h0, exp_b[i]});
      check("checksum_hand", {24'h0, got[42]}, {24'h0, vecs[vi].chk});
   endtask

   initial begin
      int nb, cyc, k;

      vecs[0].digit = 4'd7; vecs[0].scores = '0;
      vecs[0].scores[32*7 +: 32] = 32'h01020304; vecs[0].chk = 8'h03;
      vecs[1].digit = 4'd0; vecs[1].scores = '0;
      vecs[1].scores[31:0] = 32'hFFFFFFFE; vecs[1].chk = 8'h01;
      vecs[2].digit = 4'd9; vecs[2].scores = '0; vecs[2].chk = 8'h09;
      vecs[3].digit = 4'd3; vecs[3].scores = '0;
      vecs[3].scores[32*9 +: 32] = 32'h80000001; vecs[3].chk = 8'h82;

      #12;
      check("rst_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, report_done}, 32'h0);
      check("rst_ovr", {31'h0, overrun}, 32'h0);
      check("rst_data", {24'h0, tx_data}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // minimal packet
      @(negedge clk);
      predicted_digit = 4'd7; m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      check("mini_b0", {23'h0, m_tx_valid, m_tx_data}, {23'h0, 1'b1, 8'hAA});
      check("mini_busy", {31'h0, m_busy}, 32'h1);
      @(negedge clk);
      check("mini_b1", {23'h0, m_tx_valid, m_tx_data}, {23'h0, 1'b1, 8'h07});
      @(negedge clk);
      check("mini_b2", {23'h0, m_tx_valid, m_tx_data}, {23'h0, 1'b1, 8'h07});
      @(negedge clk);
      check("mini_done", {29'h0, m_report_done, m_tx_valid, m_busy},
            32'h4);
      @(negedge clk);
      check("mini_pulse", {31'h0, m_report_done}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         run_pkt(vecs[i].digit, vecs[i].scores, -1, -1, nb, cyc);
         check_pkt(i, nb);
         check("rate_cycles", cyc, 44);
      end
      check("no_overrun", {31'h0, overrun}, 32'h0);

      run_pkt(vecs[3].digit, vecs[3].scores, 10, -1, nb, cyc);
      check_pkt(3, nb);
      check("stall_cycles", cyc, 49);

      run_pkt(vecs[0].digit, vecs[0].scores, -1, 20, nb, cyc);
      check_pkt(0, nb);
      check("overrun_set", {31'h0, overrun}, 32'h1);
      run_pkt(vecs[2].digit, vecs[2].scores, -1, -1, nb, cyc);
      check_pkt(2, nb);
      check("overrun_sticky", {31'h0, overrun}, 32'h1);

      // reset while byte 15 is pending
      @(negedge clk);
      predicted_digit = vecs[1].digit; class_scores = vecs[1].scores;
      inference_done = 1'b1;
      @(negedge clk);
      inference_done = 1'b0;
      nb = 0; k = 0;
      while (nb < 15 && k < 100) begin
         if (tx_valid) nb++;
         k++;
         @(negedge clk);
      end
      check("mid_reach", nb, 15);
      #2 rst_n = 1'b0;
      #1;
      check("abort_valid", {31'h0, tx_valid}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_done", {31'h0, report_done}, 32'h0);
      check("abort_ovr", {31'h0, overrun}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_pkt(vecs[1].digit, vecs[1].scores, -1, -1, nb, cyc);
      check_pkt(1, nb);

      // pulse on the same edge as the checksum transfer is dropped
      run_pkt(vecs[2].digit, vecs[2].scores, -1, 42, nb, cyc);
      check_pkt(2, nb);
      check("final_edge_ovr", {31'h0, overrun}, 32'h1);
      check("final_edge_idle", {30'h0, tx_valid, busy}, 32'h0);
      @(negedge clk);
      check("final_edge_idle2", {30'h0, tx_valid, busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
